sigmoid_scheduler: RTL and testbench

- Time-shares one stochastic sigmoid datapath among NREQ requesters using round-robin arbitration.
- For each accepted request, the block sequences the datapath: it clears it, drives the input level, discards a warm-up period, then counts output ones over a fixed window.
- It returns the count, with the requester id, on a valid/ready response channel.
- It sits between the neuron-layer request logic and the sigmoid bitstream unit, including that unit's input generator.

---
 rtl/sigmoid_scheduler_if.sv | 37 +++
 rtl/sigmoid_scheduler.sv | 150 +++++++++++++++
 tb/tb_sigmoid_scheduler.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/sigmoid_scheduler_if.sv
// rtl/sigmoid_scheduler_if.sv - request/response bundle between requesters and the sigmoid scheduler
//
// Purpose: groups the per-requester request channel and the result channel.
// Signals:
//   req_valid  [NREQ]        per-requester request
//   req_data   [NREQ*WIDTH]  per-requester level, requester i at [i*WIDTH +: WIDTH]
//   req_ready  [NREQ]        one-hot accept strobe
//   resp_valid               result available
//   resp_ready               consumer accepts the result
//   resp_id    [clog2(NREQ)] served requester
//   resp_data  [WIN_LOG2]    saturated ones-count
// Modports: master = requesters/consumer side, slave = scheduler side.
interface sigmoid_scheduler_if #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int WIN_LOG2 = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [IDW-1:0]        resp_id;
  logic [WIN_LOG2-1:0]   resp_data;

  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data
  );

  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/sigmoid_scheduler.sv
// rtl/sigmoid_scheduler.sv - round-robin time-sharing of one stochastic sigmoid datapath
//
// Purpose: arbitrates NREQ requesters, then for the winner clears the datapath,
// drives its level, discards WARMUP output cycles and counts ones over a
// 2^WIN_LOG2-cycle window; the saturated count is returned with the id.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   bus       request/response channels (slave modport)
//   dp_clr    datapath clear (mapped to the datapath reset by the wrapper)
//   dp_en     datapath advance enable
//   dp_x      level driven to the datapath input generator
//   dp_y      datapath output bitstream
//   busy      high whenever the scheduler is not idle
module sigmoid_scheduler #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int WIN_LOG2 = 8,
  parameter int WARMUP   = 16
) (
  input  logic               clk,
  input  logic               rst,
  sigmoid_scheduler_if.slave bus,
  output logic               dp_clr,
  output logic               dp_en,
  output logic [WIDTH-1:0]   dp_x,
  input  logic               dp_y,
  output logic               busy
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = WIN_LOG2 + 1;
  localparam int WW  = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int TW  = (WIN_LOG2 > WW) ? WIN_LOG2 : WW;

  localparam logic [CW-1:0] WIN_LEN   = CW'(1) << WIN_LOG2;
  localparam logic [TW-1:0] RUN_LOAD  = TW'((1 << WIN_LOG2) - 1);
  localparam logic [TW-1:0] WARM_LOAD = TW'(WARMUP - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, WARM, RUN, DONE} state_t;

  state_t           state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   id_q;
  logic [CW-1:0]    cnt_q;
  logic [TW-1:0]    timer_q;
  logic [WIDTH-1:0] dp_x_q;
  logic             dp_clr_q;
  logic             dp_en_q;
  logic             resp_valid_q;
  logic             busy_q;

  // Round-robin scan starting at rr_ptr_q, wrapping modulo NREQ.
  logic           found_d;
  logic [IDW-1:0] win_d;
  int             scan_idx;

  always_comb begin
    found_d  = 1'b0;
    win_d    = '0;
    scan_idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!found_d && bus.req_valid[scan_idx]) begin
        found_d = 1'b1;
        win_d   = IDW'(scan_idx);
      end
    end
  end

  logic [IDW-1:0] rr_ptr_d;
  assign rr_ptr_d = IDW'((int'(win_d) + 1) % NREQ);

  // Grant is combinational so the requester sees it in the accept cycle.
  assign bus.req_ready = (state_q == IDLE && found_d) ? (NREQ'(1) << win_d) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      cnt_q        <= '0;
      timer_q      <= '0;
      dp_x_q       <= '0;
      dp_clr_q     <= 1'b0;
      dp_en_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found_d) begin
            dp_x_q   <= bus.req_data[win_d*WIDTH +: WIDTH];
            id_q     <= win_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= '0;
            dp_clr_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= CLEAR;
          end
        end
        CLEAR: begin
          dp_clr_q <= 1'b0;
          dp_en_q  <= 1'b1;
          if (WARMUP == 0) begin
            timer_q <= RUN_LOAD;
            state_q <= RUN;
          end else begin
            timer_q <= WARM_LOAD;
            state_q <= WARM;
          end
        end
        WARM: begin
          // dp_y is deliberately ignored while the datapath settles.
          if (timer_q == '0) begin
            timer_q <= RUN_LOAD;
            state_q <= RUN;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        RUN: begin
          cnt_q <= cnt_q + CW'(dp_y);
          if (timer_q == '0) begin
            dp_en_q      <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= DONE;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        DONE: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A full window of ones (2^WIN_LOG2) does not fit the result width; clamp it.
  assign bus.resp_data  = (cnt_q == WIN_LEN) ? {WIN_LOG2{1'b1}} : cnt_q[WIN_LOG2-1:0];
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = id_q;
  assign dp_clr         = dp_clr_q;
  assign dp_en          = dp_en_q;
  assign dp_x           = dp_x_q;
  assign busy           = busy_q;
endmodule

// File: tb/tb_sigmoid_scheduler.sv
// tb/tb_sigmoid_scheduler.sv - randomized self-checking bench for sigmoid_scheduler
//
// Purpose: drives requests and dp_y patterns, predicts grant order, phase
// timing and the saturated ones-count from a behavioural model.
// Ports: none (top-level bench).
module tb_sigmoid_scheduler;
  localparam int NREQ     = 4;
  localparam int WIDTH    = 8;
  localparam int WIN_LOG2 = 8;
  localparam int WARMUP   = 16;
  localparam int WIN      = 1 << WIN_LOG2;
  localparam int RUN0     = WARMUP + 2;
  localparam int RUNN     = WARMUP + 1 + WIN;
  localparam int LAT      = WARMUP + 2 + WIN;

  logic             clk = 1'b0;
  logic             rst;
  logic             dp_clr;
  logic             dp_en;
  logic [WIDTH-1:0] dp_x;
  logic             dp_y;
  logic             busy;

  sigmoid_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH), .WIN_LOG2(WIN_LOG2)) bus ();

  sigmoid_scheduler #(
    .NREQ(NREQ), .WIDTH(WIDTH), .WIN_LOG2(WIN_LOG2), .WARMUP(WARMUP)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .dp_clr(dp_clr),
    .dp_en (dp_en),
    .dp_x  (dp_x),
    .dp_y  (dp_y),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int               n_cmp = 0;
  int               n_err = 0;
  int               mptr  = 0;
  logic [WIDTH-1:0] levels [NREQ];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_winner(input logic [NREQ-1:0] mask);
    for (int k = 0; k < NREQ; k++)
      if (mask[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [31:0] grant_vec(input int w);
    return (w < 0) ? 32'd0 : (32'd1 << w);
  endfunction

  task automatic drive_data();
    for (int i = 0; i < NREQ; i++) bus.req_data[i*WIDTH +: WIDTH] = levels[i];
  endtask

  // y-pattern by cycle index relative to the accept edge.
  function automatic logic ybit(input int mode, input int c);
    case (mode)
      0: return 1'b1;
      1: return 1'b0;
      2: return ((c - RUN0) % 2 == 0);
      3: return (c < RUN0);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic txn(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] next_mask,
                     input int mode, input int hold, input int rst_at);
    int w, sum, exp_data, perr;
    logic [WIDTH-1:0] lvl;
    logic yb, dropped;
    bus.resp_ready = (hold == 0);
    bus.req_valid  = mask;
    #1;
    w = model_winner(mask);
    check_eq("grant", bus.req_ready, grant_vec(w));
    lvl = levels[w];
    @(posedge clk);
    mptr = (w + 1) % NREQ;
    #1 bus.req_valid = next_mask;
    perr = 0; sum = 0; dropped = 1'b0;
    for (int c = 1; c <= LAT && !dropped; c++) begin
      @(negedge clk);
      if (c == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mptr = 0;
        dropped = 1'b1;
      end else begin
        if (dp_clr !== (c == 1)) perr++;
        if (dp_en !== (c >= 2 && c <= RUNN)) perr++;
        if (bus.resp_valid !== (c == LAT)) perr++;
        if (busy !== 1'b1) perr++;
        if (dp_x !== lvl) perr++;
        if (bus.req_ready !== '0) perr++;
        yb = ybit(mode, c);
        dp_y = yb;
        if (c >= RUN0 && c <= RUNN) sum += int'(yb);
      end
    end
    check_eq("phase", perr, 0);
    if (dropped) begin
      check_eq("rst_busy", busy, 0);
      check_eq("rst_en", dp_en, 0);
      check_eq("rst_rv", bus.resp_valid, 0);
      check_eq("rst_dpx", dp_x, 0);
      perr = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus.resp_valid !== 1'b0 || busy !== 1'b0) perr++;
      end
      check_eq("no_resp", perr, 0);
    end else begin
      exp_data = (sum >= WIN) ? WIN - 1 : sum;
      check_eq("resp_valid", bus.resp_valid, 1);
      check_eq("resp_id", bus.resp_id, w);
      check_eq("resp_data", bus.resp_data, exp_data);
      if (hold > 0) begin
        perr = 0;
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          if (bus.resp_valid !== 1'b1 || bus.resp_data !== WIN_LOG2'(exp_data) ||
              bus.resp_id !== 2'(w) || bus.req_ready !== '0) perr++;
        end
        check_eq("hold", perr, 0);
        bus.resp_ready = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      check_eq("busy_after", busy, 0);
      check_eq("grant_after", bus.req_ready, grant_vec(model_winner(bus.req_valid)));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.resp_ready = 1'b0;
    dp_y = 1'b0;
    for (int i = 0; i < NREQ; i++) levels[i] = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", bus.req_ready, 0);
    check_eq("rst_resp_valid", bus.resp_valid, 0);
    check_eq("rst_resp_id", bus.resp_id, 0);
    check_eq("rst_resp_data", bus.resp_data, 0);
    check_eq("rst_dp_clr", dp_clr, 0);
    check_eq("rst_dp_en", dp_en, 0);
    check_eq("rst_dp_x", dp_x, 0);
    check_eq("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    levels[0] = 8'h80;
    drive_data();
    txn(4'b0001, 4'b0000, 0, 0, 0);
    txn(4'b0001, 4'b0000, 1, 0, 0);
    txn(4'b0001, 4'b0000, 2, 0, 0);
    txn(4'b0001, 4'b0000, 3, 0, 0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mptr = 0;
    levels[0] = 8'h10; levels[1] = 8'h20; levels[2] = 8'h30; levels[3] = 8'h40;
    drive_data();
    for (int k = 0; k < 4; k++) txn(4'b1111, 4'b1111, 4, 0, 0);
    txn(4'b1111, 4'b0010, 4, 10, 0);
    txn(4'b0010, 4'b0000, 4, 0, RUN0 + 99);
    txn(4'b1111, 4'b0000, 4, 0, 0);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NREQ; i++)
        if (!bus.req_valid[i]) levels[i] = WIDTH'($urandom);
      drive_data();
      txn(NREQ'($urandom_range(1, 15)), NREQ'($urandom_range(0, 15)), 4,
          $urandom_range(0, 3), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
